conv_frame_ctrl: RTL and testbench
==================================

# conv_frame_ctrl

Frame sequencer for the 3x3 Sobel convolution datapath. It accepts a raw 12-bit pixel stream and drives the datapath's `read`, `x`, `y`, `data_in` and `vertical` inputs in raster order. It then collects the datapath's `valid`/`data_out` results, tags the last result of each frame, and reports frame completion and stream errors. It sits between the camera capture/grayscale stage and the display frame writer.

## Interface
- `WIDTH`, 1280: pixels per line; also the datapath line-delay depth.
- `HEIGHT`, 960: lines per frame.
- `DRAIN_MAX`, 2*WIDTH: cycles allowed in DRAIN before timeout.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse; arms one frame from IDLE or DONE, ignored otherwise.
- `cfg_vertical` input 1: filter orientation, sampled on `start`.
- `in_valid` input 1: upstream pixel strobe.
- `in_sof` input 1: first pixel of a frame; qualified by `in_valid`.
- `in_data` input 12: upstream pixel.
- `conv_read` output 1: pixel-valid tag to the datapath.
- `conv_x`, `conv_y` output 11 each: coordinates of `conv_data`.
- `conv_data` output 12: pixel to the datapath.
- `conv_vertical` output 1: latched orientation.
- `conv_valid` input 1: datapath result strobe.
- `conv_out` input 12: datapath result.
- `out_valid` output 1: registered result strobe.
- `out_data` output 12: registered result.
- `out_last` output 1: marks the WIDTH*HEIGHT-th result.
- `busy` output 1: high in ARM, STREAM and DRAIN.
- `done` output 1: one-cycle pulse when a frame completes.
- `err` output 1: sticky error flag; cleared by `start`.

## Operation
- States: IDLE, ARM, STREAM, DRAIN, DONE.
- IDLE/DONE -> ARM on `start`:
  - latch `cfg_vertical`;
  - clear `err`, the output counter and the coordinate counters.
- ARM: pixels without `in_sof` are discarded. `in_valid && in_sof` -> STREAM, and that pixel is issued at (0,0).
- STREAM: each accepted pixel is issued with `conv_read`=1 at the current (x,y), then x increments. When x = WIDTH-1, x wraps to 0 and y increments. The pixel at (WIDTH-1, HEIGHT-1) -> DRAIN.
- The datapath shift registers run every cycle, so pixels within a frame must be contiguous. Any cycle in STREAM with `in_valid`=0 sets `err`; streaming continues without advancing coordinates.
- `in_sof` in STREAM sets `err`; the pixel is treated as ordinary.
- DRAIN: `conv_read`=0 and `conv_data`=0 are issued every cycle so that in-flight pixels shift through.
- DRAIN -> DONE when the output counter reaches WIDTH*HEIGHT. Pulse `done` that cycle.
- DRAIN timeout: after DRAIN_MAX cycles without reaching the count, set `err` and go to DONE with `done` pulsed.
- Output path, in every state except IDLE:
  - `conv_valid` -> `out_valid`=1 and `out_data`=`conv_out` on the next cycle;
  - increment the 21-bit output counter;
  - `out_last`=1 with the result whose pre-increment count is WIDTH*HEIGHT-1.
- Results arriving after the count is reached set `err` and are still forwarded.
- Outside STREAM, `conv_read`=0 and `conv_x`, `conv_y`, `conv_data` hold 0.

## Timing
- Reset values:
  - state IDLE;
  - every output 0, including `conv_vertical`, `err`, `out_last`, `busy` and `done`.
- `conv_*` outputs are registered: accepted pixel at cycle t -> `conv_read`/`conv_data` at t+1.
- Result path: `conv_valid` at t -> `out_valid` at t+1.
- End-to-end: the first result leaves about WIDTH+4 cycles after the (0,0) pixel enters (datapath delay WIDTH+2 plus 2 register stages). DRAIN normally lasts WIDTH+3 cycles.
- `start` in ARM, STREAM or DRAIN is ignored; it does not clear `err`.
- `start` and `conv_valid` in the same DONE cycle: the counter clears and that result is not counted.
- `rst` mid-frame returns to IDLE immediately and drops all in-flight results. The datapath is reset by the same `rst` (inverted at the instantiation site).
- `done` and `out_last` coincide with the final `out_valid` on a clean frame.

## Structure
- Shared package `conv_pkg`:
  - `conv_state_e` (the five states);
  - `PIX_W`=12, `COORD_W`=11, `CNT_W`=21;
  - `conv_pix_t` packed struct {read, y, x, data} (35 bits), matching the datapath tap format.
- Natural sub-module: `raster_counter` (x/y wrap counter with `last_px` output), reusable by the frame writer.
- Everything else sits in one module: state register, output counter, drain timer, output registers.

## Test plan
- Clean frame (bench `WIDTH`=8, `HEIGHT`=4):
  - stimulus: `start`, `cfg_vertical`=1, then 32 contiguous pixels with `in_sof` on the first;
  - required: `conv_x` walks 0..7 and `conv_y` walks 0..3; exactly 32 `out_valid`; `out_last`+`done` on the same cycle; `err`=0; `busy` low afterwards.
- ARM filtering:
  - stimulus: 5 pixels with no `in_sof`, then a pixel with `in_sof`;
  - required: no `conv_read` for the first 5; the `in_sof` pixel issued at (0,0).
- Gap mid-line:
  - stimulus: `in_valid` low for one cycle at pixel 10;
  - required: `err`=1; coordinates resume at (2,1) with the next pixel.
- Drain timeout:
  - stimulus: datapath model suppresses `conv_valid` after 20 results;
  - required: `done` after `DRAIN_MAX`=16 DRAIN cycles; `err`=1; `out_last` never asserted.
- Reset mid-frame:
  - stimulus: `rst` at pixel 17;
  - required: all outputs 0 in the same cycle; a subsequent `start` and clean frame gives 32 results with `err`=0.
- `start` while busy:
  - stimulus: `start` in STREAM with `cfg_vertical` flipped;
  - required: `conv_vertical` unchanged; frame completes normally.

Source files
------------

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the Sobel frame sequencer and its neighbours:
//   conv_state_e : frame sequencer states
//   PIX_W        : pixel width
//   COORD_W      : x/y coordinate width
//   CNT_W        : result counter width (holds 1280*960)
//   conv_pix_t   : datapath tap word {read, y, x, data}, 35 bits
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int PIX_W   = 12;
  localparam int COORD_W = 11;
  localparam int CNT_W   = 21;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } conv_state_e;

  typedef struct packed {
    logic               read;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [PIX_W-1:0]   data;
  } conv_pix_t;

endpackage

// File: rtl/conv_frame_ctrl_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Raster-order x/y position counter. x runs 0..WIDTH-1, then wraps and y
// increments; y wraps after HEIGHT-1. last_px_o flags the final position of
// the frame so the caller can act on the pixel being consumed there.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : synchronous return to (0,0)
//   adv_i      : advance one position
//   x_o, y_o   : current position
//   last_px_o  : current position is (WIDTH-1, HEIGHT-1)
// -----------------------------------------------------------------------------
module raster_counter
  import conv_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_px_o
);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               x_end;
  logic               y_end;

  assign x_end     = (x_q == COORD_W'(WIDTH - 1));
  assign y_end     = (y_q == COORD_W'(HEIGHT - 1));
  assign last_px_o = x_end && y_end;
  assign x_o       = x_q;
  assign y_o       = y_q;

  // position register: clear wins over advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= COORD_W'(0);
      y_q <= COORD_W'(0);
    end else if (clr_i) begin
      x_q <= COORD_W'(0);
      y_q <= COORD_W'(0);
    end else if (adv_i) begin
      if (x_end) begin
        x_q <= COORD_W'(0);
        y_q <= y_end ? COORD_W'(0) : y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// -----------------------------------------------------------------------------
// conv_frame_ctrl
// Frame sequencer for the 3x3 Sobel datapath. Feeds a contiguous raw pixel
// stream into the datapath in raster order, forwards the datapath results,
// tags the last result of the frame and reports completion and stream errors.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, cfg_vertical      : arm one frame, orientation sampled on start
//   in_valid/in_sof/in_data  : upstream pixel stream
//   conv_read/x/y/data       : registered pixel tap into the datapath
//   conv_vertical            : latched orientation
//   conv_valid/conv_out      : datapath result
//   out_valid/data/last      : registered result stream
//   busy, done, err          : status (err is sticky until the next start)
// -----------------------------------------------------------------------------
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 960,
  parameter int DRAIN_MAX = 2 * WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_vertical,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_data,
  output logic               conv_read,
  output logic [COORD_W-1:0] conv_x,
  output logic [COORD_W-1:0] conv_y,
  output logic [PIX_W-1:0]   conv_data,
  output logic               conv_vertical,
  input  logic               conv_valid,
  input  logic [PIX_W-1:0]   conv_out,
  output logic               out_valid,
  output logic [PIX_W-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int TMR_W = $clog2(DRAIN_MAX + 1);

  conv_state_e        state_q;
  conv_pix_t          conv_pix_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [TMR_W-1:0]   tmr_q;
  logic               vert_q;
  logic               out_valid_q;
  logic [PIX_W-1:0]   out_data_q;
  logic               out_last_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               start_ok;
  logic               accept;
  logic               count_en;
  logic               late_result;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               last_px;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_ok),
    .adv_i     (accept),
    .x_o       (pos_x),
    .y_o       (pos_y),
    .last_px_o (last_px)
  );

  // start qualification, pixel acceptance and next result count
  always_comb begin
    start_ok = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE:   start_ok = start;
      ST_ARM:    accept   = in_valid && in_sof;
      ST_STREAM: accept   = in_valid;
      ST_DRAIN:  accept   = 1'b0;
      ST_DONE:   start_ok = start;
      default:   accept   = 1'b0;
    endcase

    // a result coinciding with an accepted start belongs to no frame
    count_en    = conv_valid && (state_q != ST_IDLE) && !start_ok;
    late_result = count_en && (cnt_q >= CNT_W'(TOTAL));

    if (start_ok) begin
      cnt_d = CNT_W'(0);
    end else if (count_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // frame state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      conv_pix_q  <= '0;
      cnt_q       <= CNT_W'(0);
      tmr_q       <= TMR_W'(0);
      vert_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= PIX_W'(0);
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      conv_pix_q  <= '0;

      if (conv_valid && (state_q != ST_IDLE)) begin
        out_valid_q <= 1'b1;
        out_data_q  <= conv_out;
        out_last_q  <= count_en && (cnt_q == CNT_W'(TOTAL - 1));
      end

      if (accept) begin
        conv_pix_q.read <= 1'b1;
        conv_pix_q.x    <= pos_x;
        conv_pix_q.y    <= pos_y;
        conv_pix_q.data <= in_data;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_q <= ST_ARM;
            vert_q  <= cfg_vertical;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (accept) begin
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // the datapath shifts every cycle, so a hole or a second SOF
          // corrupts the frame geometry
          if (!in_valid || in_sof) begin
            err_q <= 1'b1;
          end
          if (accept && last_px) begin
            state_q <= ST_DRAIN;
            tmr_q   <= TMR_W'(0);
          end
        end
        ST_DRAIN: begin
          if (cnt_d >= CNT_W'(TOTAL)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tmr_q == TMR_W'(DRAIN_MAX - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (late_result) begin
        err_q <= 1'b1;
      end
    end
  end

  assign conv_read     = conv_pix_q.read;
  assign conv_x        = conv_pix_q.x;
  assign conv_y        = conv_pix_q.y;
  assign conv_data     = conv_pix_q.data;
  assign conv_vertical = vert_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_frame_ctrl
// Directed bench for conv_frame_ctrl with an 8x4 frame. A small datapath model
// delays conv_read/conv_data by WIDTH+2 cycles and returns data ^ 12'h5A5.
// -----------------------------------------------------------------------------
module tb_conv_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DM = 16;
  localparam int D  = W + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cfg_vertical = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [11:0] in_data = 12'd0;
  logic        conv_read;
  logic [10:0] conv_x;
  logic [10:0] conv_y;
  logic [11:0] conv_data;
  logic        conv_vertical;
  logic        conv_valid;
  logic [11:0] conv_out;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  conv_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .DRAIN_MAX(DM)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_vertical  (cfg_vertical),
    .in_valid      (in_valid),
    .in_sof        (in_sof),
    .in_data       (in_data),
    .conv_read     (conv_read),
    .conv_x        (conv_x),
    .conv_y        (conv_y),
    .conv_data     (conv_data),
    .conv_vertical (conv_vertical),
    .conv_valid    (conv_valid),
    .conv_out      (conv_out),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // datapath model: fixed delay line, result count can be capped
  logic [D-1:0] pv;
  logic [11:0]  pd [D];
  int           model_cnt;
  int           model_lim = 32'h4000_0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv        <= '0;
      model_cnt <= 0;
      for (int i = 0; i < D; i++) pd[i] <= 12'd0;
    end else begin
      pv    <= {pv[D-2:0], conv_read};
      pd[0] <= conv_data;
      for (int i = 1; i < D; i++) pd[i] <= pd[i-1];
      if (conv_valid) model_cnt <= model_cnt + 1;
    end
  end

  assign conv_valid = pv[D-1] && (model_cnt < model_lim);
  assign conv_out   = pd[D-1] ^ 12'h5A5;

  function automatic logic [11:0] pix(input int k);
    logic [31:0] t;
    t = k * 37 + 291;
    return t[11:0];
  endfunction

  // result monitor: counts results, last tags, coincidences and data errors
  int nv = 0, nlast = 0, ncoinc = 0, ndbad = 0;
  int frame_base = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        nv <= nv + 1;
        if ((nv - frame_base) < W * H && out_data !== (pix(nv - frame_base) ^ 12'h5A5))
          ndbad <= ndbad + 1;
      end
      if (out_last) nlast <= nlast + 1;
      if (out_last && done && out_valid) ncoinc <= ncoinc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_conv_read"}, conv_read, 1'b0);
    check_eq({tag, "_conv_x"}, conv_x, 11'd0);
    check_eq({tag, "_conv_y"}, conv_y, 11'd0);
    check_eq({tag, "_conv_data"}, conv_data, 12'd0);
    check_eq({tag, "_conv_vertical"}, conv_vertical, 1'b0);
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_out_data"}, out_data, 12'd0);
    check_eq({tag, "_out_last"}, out_last, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_err"}, err, 1'b0);
  endtask

  task automatic do_start(input string name, input logic vert);
    start = 1'b1;
    cfg_vertical = vert;
    tick();
    start = 1'b0;
    cfg_vertical = !vert;
    frame_base = nv;
    check_eq({name, "_busy_arm"}, busy, 1'b1);
    check_eq({name, "_vert_latch"}, conv_vertical, vert);
    check_eq({name, "_err_cleared"}, err, 1'b0);
  endtask

  // issue one pixel and check the registered tap on the following sample
  task automatic send_pix(input string name, input int k, input int start_at, input logic vert);
    in_valid = 1'b1;
    in_sof   = (k == 0);
    in_data  = pix(k);
    start    = (k == start_at);
    tick();
    start    = 1'b0;
    check_eq({name, "_read"}, conv_read, 1'b1);
    check_eq({name, "_x"}, conv_x, k % W);
    check_eq({name, "_y"}, conv_y, k / W);
    check_eq({name, "_data"}, conv_data, pix(k));
    check_eq({name, "_vert_hold"}, conv_vertical, vert);
  endtask

  task automatic run_frame(input string name, input logic vert, input int junk,
                           input int gap_at, input int start_at, input int exp_drain,
                           input int exp_res, input logic exp_err, input int exp_last);
    int  v0, l0, c0, b0, dr;
    bit  seen;
    do_start(name, vert);
    v0 = nv; l0 = nlast; c0 = ncoinc; b0 = ndbad;
    for (int j = 0; j < junk; j++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_data = 12'hEEE;
      tick();
      check_eq({name, "_arm_discard"}, conv_read, 1'b0);
    end
    for (int k = 0; k < W * H; k++) begin
      if (k == gap_at) begin
        in_valid = 1'b0; in_sof = 1'b0;
        tick();
        check_eq({name, "_gap_read"}, conv_read, 1'b0);
        check_eq({name, "_gap_err"}, err, 1'b1);
      end
      send_pix(name, k, start_at, vert);
    end
    in_valid = 1'b0; in_sof = 1'b0;
    dr = 0; seen = 1'b0;
    for (int c = 1; c <= 4 * W && !seen; c++) begin
      tick();
      check_eq({name, "_drain_read"}, conv_read, 1'b0);
      if (done) begin
        seen = 1'b1;
        dr = c;
      end
    end
    check_eq({name, "_done_seen"}, seen, 1'b1);
    check_eq({name, "_drain_len"}, dr, exp_drain);
    check_eq({name, "_err"}, err, exp_err);
    tick();
    check_eq({name, "_busy_after"}, busy, 1'b0);
    check_eq({name, "_done_pulse"}, done, 1'b0);
    check_eq({name, "_results"}, nv - v0, exp_res);
    check_eq({name, "_last_cnt"}, nlast - l0, exp_last);
    check_eq({name, "_last_done_coinc"}, ncoinc - c0, exp_last);
    check_eq({name, "_data_errs"}, ndbad - b0, 0);
    check_eq({name, "_vert_final"}, conv_vertical, vert);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // clean frame, DRAIN lasts W+3 cycles
    run_frame("clean", 1'b1, 0, -1, -1, W + 3, W * H, 1'b0, 1);
    // non-SOF pixels discarded in ARM
    run_frame("armflt", 1'b0, 5, -1, -1, W + 3, W * H, 1'b0, 1);
    // hole before pixel 10: err, next pixel at (2,1)
    run_frame("gap", 1'b1, 0, 10, -1, W + 3, W * H, 1'b1, 1);
    // datapath stalls after 20 results: timeout after DM drain cycles
    model_lim = model_cnt + 20;
    run_frame("tmo", 1'b0, 0, -1, -1, DM, 20, 1'b1, 0);
    model_lim = 32'h4000_0000;

    // reset at pixel 17
    do_start("rstmid", 1'b1);
    for (int k = 0; k < 17; k++) send_pix("rstmid", k, -1, 1'b1);
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0;
    #1;
    check_all_zero("rstmid_async");
    tick();
    rst = 1'b0;
    tick();
    run_frame("post_rst", 1'b1, 0, -1, -1, W + 3, W * H, 1'b0, 1);

    // start during STREAM with orientation flipped is ignored
    run_frame("busy_start", 1'b1, 0, -1, 5, W + 3, W * H, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
